// File: rtl/scan_host_bridge_if.sv
// Host byte-stream link plus the scan_controller hookup for scan_host_bridge.
// The bridge connects through the slave modport; the host/controller side uses master.
interface scan_host_bridge_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [8:0] active_select;
    logic [7:0] inputs;
    logic [7:0] outputs;
    logic       ready;

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready, outputs, ready,
        output cmd_ready, rsp_valid, rsp_data, active_select, inputs
    );

    modport master (
        output cmd_valid, cmd_data, rsp_ready, outputs, ready,
        input  cmd_ready, rsp_valid, rsp_data, active_select, inputs
    );
endinterface

// File: rtl/scan_host_bridge.sv
// Byte-command front end for scan_controller: stages select/inputs, commits on ready pulses.
// Optional READ timeout is enabled by defining SCAN_HOST_TIMEOUT_EN.
module scan_host_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    scan_host_bridge_if.slave  bus
);

    localparam int unsigned SEL_W  = 9;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG_SEL,
        S_ARG_IN,
        S_WAIT_FRESH,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_sel_shadow;
    logic [SEL_W-1:0]    r_active_select;
    logic [DATA_W-1:0]   r_in_shadow;
    logic [DATA_W-1:0]   r_inputs;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_valid;
    logic                r_pending;
    logic [CNT_W-1:0]    r_fresh_cnt;

    logic                w_cmd_ready;
    logic                w_cmd_fire;
    logic                w_fresh_ok;
    logic                w_timeout;
    logic                w_sel_hi_wr;
    logic                w_sel_lo_wr;
    logic                w_in_wr;
    logic                w_rsp_load;
    logic [DATA_W-1:0]   w_rsp_data_nxt;

    assign w_cmd_ready = ((r_state == S_IDLE) || (r_state == S_ARG_SEL) || (r_state == S_ARG_IN)) && !reset;
    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    // Outputs are trustworthy only once both post-commit pulses have passed and no new commit is due.
    assign w_fresh_ok  = (r_fresh_cnt == CNT_W'(0)) && !r_pending && !bus.ready;

`ifdef SCAN_HOST_TIMEOUT_EN
    localparam int unsigned TO_W = 16;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;

    // Held at zero outside WAIT_FRESH so every entry starts a fresh count.
    always_ff @(posedge clk) begin : to_cnt_reg
        if (reset || (r_state != S_WAIT_FRESH)) r_to_cnt <= '0;
        else                                    r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    assign w_timeout = (r_state == S_WAIT_FRESH) && (r_to_cnt == TO_LIM);
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin : state_reg
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    case (bus.cmd_data)
                        8'h10, 8'h11: w_state_nxt = S_ARG_SEL;
                        8'h20:        w_state_nxt = S_ARG_IN;
                        8'h30:        w_state_nxt = S_WAIT_FRESH;
                        default:      w_state_nxt = S_RESP;
                    endcase
                end
            end
            S_ARG_SEL, S_ARG_IN: if (w_cmd_fire) w_state_nxt = S_IDLE;
            S_WAIT_FRESH:        if (w_fresh_ok || w_timeout) w_state_nxt = S_RESP;
            S_RESP:              if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default:             w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin : output_decode
        w_sel_hi_wr    = 1'b0;
        w_sel_lo_wr    = 1'b0;
        w_in_wr        = 1'b0;
        w_rsp_load     = 1'b0;
        w_rsp_data_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    case (bus.cmd_data)
                        8'h10, 8'h11: w_sel_hi_wr = 1'b1;
                        8'h20, 8'h30: ;
                        8'h40: begin
                            w_rsp_load     = 1'b1;
                            w_rsp_data_nxt = {6'b0, r_pending, (r_fresh_cnt == CNT_W'(0))};
                        end
                        default: begin
                            w_rsp_load     = 1'b1;
                            w_rsp_data_nxt = 8'hFF;
                        end
                    endcase
                end
            end
            S_ARG_SEL: w_sel_lo_wr = w_cmd_fire;
            S_ARG_IN:  w_in_wr     = w_cmd_fire;
            S_WAIT_FRESH: begin
                if (w_fresh_ok) begin
                    w_rsp_load     = 1'b1;
                    w_rsp_data_nxt = bus.outputs;
                end else if (w_timeout) begin
                    w_rsp_load     = 1'b1;
                    w_rsp_data_nxt = 8'hEE;
                end
            end
            default: ;
        endcase
    end

    // Commit uses pre-write shadows; a same-cycle shadow write keeps pending set for the next pulse.
    always_ff @(posedge clk) begin : shadow_commit
        if (reset) begin
            r_sel_shadow    <= '0;
            r_in_shadow     <= '0;
            r_active_select <= '0;
            r_inputs        <= '0;
            r_pending       <= 1'b0;
            r_fresh_cnt     <= CNT_W'(2);
        end else begin
            if (w_sel_hi_wr) r_sel_shadow[8]   <= bus.cmd_data[0];
            if (w_sel_lo_wr) r_sel_shadow[7:0] <= bus.cmd_data;
            if (w_in_wr)     r_in_shadow       <= bus.cmd_data;

            if (bus.ready && r_pending) begin
                r_active_select <= r_sel_shadow;
                r_inputs        <= r_in_shadow;
                r_fresh_cnt     <= CNT_W'(2);
            end else if (bus.ready && (r_fresh_cnt != CNT_W'(0))) begin
                r_fresh_cnt <= r_fresh_cnt - CNT_W'(1);
            end

            if (w_sel_lo_wr || w_in_wr)  r_pending <= 1'b1;
            else if (bus.ready)          r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin : rsp_reg
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rsp_data_nxt;
        end else if ((r_state == S_RESP) && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.cmd_ready     = w_cmd_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.active_select = r_active_select;
    assign bus.inputs        = r_inputs;

endmodule
